imem_refill_arbiter: RTL
========================

# imem_refill_arbiter

Sequencer and arbiter for the single backing-memory port shared by the instruction cache and the data side. It turns an icache miss into an 8-word line refill from a word-wide, variable-latency memory, and serves single-word data reads and writes. It decides who owns the memory port using round-robin priority, and tells the icache when the line is ready to write. It sits between the icache/CacheFSM pair and the main memory.

## Interface
Parameters:
- LINE_WORDS, 8, words per cache line (power of 2; offset width = log2)
- ADDR_W, 32, address width

Ports:
- CLK  in  1  clock, all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- ic_req  in  1  icache miss refill request; level, held until ic_done
- ic_addr  in  32  miss PC; line base = ic_addr with bits [4:0] cleared
- ic_line  out  32*LINE_WORDS  refilled line; word i at bits [32i+31:32i]
- ic_done  out  1  one-cycle pulse: ic_line valid, icache writes line
- ic_busy  out  1  high from grant through ic_done cycle; drives pc_stall
- d_req  in  1  data access request; level, held until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  word address (bits [1:0] ignored)
- d_wdata  in  32  write data
- d_rdata  out  32  read data, valid in d_done cycle, held until next data read
- d_done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory word address (bits [1:0] = 0)
- mem_wdata  out  32  memory write data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid; never in the same cycle as the gnt for the same read

## Operation
- States: IDLE, IC_REQ, IC_WAIT, IC_DONE, D_REQ, D_WAIT, D_DONE.
- IDLE: grant on requests present this cycle.
  - Only ic_req: go to IC_REQ.
  - Only d_req: go to D_REQ.
  - Both: grant the requester NOT served last. The last_grant flag resets to "data", so the icache wins first contention.
- At grant, latch the address: line base for icache, d_addr[31:2] for data. Also latch d_we and d_wdata. Input changes after grant are ignored.
- IC_REQ:
  - mem_req=1, mem_we=0, mem_addr = {base[31:5], cnt, 2'b00}.
  - On mem_gnt go to IC_WAIT.
- IC_WAIT: on mem_rvalid, store mem_rdata into word cnt.
  - If cnt==LINE_WORDS-1, go to IC_DONE.
  - Otherwise cnt++ and return to IC_REQ.
- IC_DONE: ic_done=1 for one cycle, cnt cleared, last_grant=icache, go to IDLE.
- D_REQ:
  - mem_req=1, mem_we=latched we.
  - On mem_gnt: writes go to D_DONE, reads go to D_WAIT.
- D_WAIT: on mem_rvalid, capture d_rdata and go to D_DONE.
- D_DONE: d_done=1 for one cycle, last_grant=data, go to IDLE.
- One outstanding memory transaction at a time. mem_rvalid outside IC_WAIT/D_WAIT is ignored.
- A burst is never pre-empted. Deassertion of ic_req mid-burst does not abort it; the line still completes and ic_done still pulses.
- A requester still asserting in its done cycle is not re-granted that cycle. The IDLE cycle always intervenes.

## Timing
- Reset (async assert, sync release) gives:
  - state IDLE, cnt=0, last_grant=data
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - ic_done=0, ic_busy=0, d_done=0
  - ic_line=0, d_rdata=0
- Reset mid-burst abandons the transaction with no done pulse. Stale in-flight mem_rvalid after release is ignored because the controller is in IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from mem_* inputs to outputs.
- Best-case icache refill: grant edge, then 2 cycles/word (gnt in IC_REQ, rvalid in first IC_WAIT cycle).
  - ic_done is asserted 2*LINE_WORDS+1 = 17 cycles after leaving IDLE.
- Best-case data read: d_done 3 cycles after leaving IDLE. Best-case write: 2 cycles.
- ic_busy is high in IC_REQ, IC_WAIT and IC_DONE.
- ic_line words update only on their captured rvalid. The whole line is stable during the ic_done cycle and held until the next refill starts.

## Test plan
- Reset then ic_req=1, ic_addr=0x0000_0124, memory returns word = address, zero-wait -> 8 reads:
  - mem_addr sequence 0x120..0x13C
  - ic_done at cycle 17
  - ic_line word i = 0x120+4i
- Both ic_req and d_req (read 0x400) first asserted the same cycle -> icache served first, data read follows. Repeat contention -> data served first.
- Data write d_addr=0x803, d_wdata=0xDEADBEEF, gnt delayed 3 cycles -> mem_addr=0x800, mem_we=1 held until gnt; d_done one cycle after gnt; no wait for rvalid.
- Refill with mem_rvalid delayed 0–5 random cycles per word, ic_req dropped after word 2 -> burst completes, ic_done pulses once, ic_busy high throughout.
- RST_N pulled low mid-burst at word 4 with in-flight read -> outputs zero immediately. Stray rvalid after release is ignored. A new ic_req restarts at word 0.
- Spurious mem_rvalid in IDLE and D_REQ -> no state change, d_rdata unchanged.

Source files
------------

// File: rtl/imem_refill_arbiter.sv
// Shared backing-memory port sequencer: icache line refills and single-word data accesses,
// round-robin arbitrated, one outstanding memory transaction at a time.
module imem_refill_arbiter #(
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   // icache refill side
   input  logic                       ic_req,
   input  logic [ADDR_W-1:0]          ic_addr,
   output logic [32*LINE_WORDS-1:0]   ic_line,
   output logic                       ic_done,
   output logic                       ic_busy,
   // data side
   input  logic                       d_req,
   input  logic                       d_we,
   input  logic [ADDR_W-1:0]          d_addr,
   input  logic [31:0]                d_wdata,
   output logic [31:0]                d_rdata,
   output logic                       d_done,
   // backing memory
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [31:0]                mem_wdata,
   input  logic                       mem_gnt,
   input  logic                       mem_rvalid,
   input  logic [31:0]                mem_rdata
);

   localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
   localparam int unsigned BASE_W = ADDR_W - OFF_W - 2;
   localparam int unsigned WADR_W = ADDR_W - 2;
   localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StIcReq,
      StIcWait,
      StIcDone,
      StDReq,
      StDWait,
      StDDone
   } state_e;

   state_e                         state_q, state_d;
   logic [OFF_W-1:0]               cnt_q, cnt_d;
   logic                           last_ic_q, last_ic_d;
   logic [BASE_W-1:0]              ic_base_q, ic_base_d;
   logic [WADR_W-1:0]              d_waddr_q, d_waddr_d;
   logic                           d_we_q, d_we_d;
   logic [31:0]                    d_wdata_q, d_wdata_d;
   logic [LINE_WORDS-1:0][31:0]    line_q, line_d;
   logic [31:0]                    rdata_q, rdata_d;

   // Line-offset and byte-offset address bits are dropped at grant time.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{ic_addr[OFF_W+1:0], d_addr[1:0]};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         last_ic_q <= 1'b0;
         ic_base_q <= '0;
         d_waddr_q <= '0;
         d_we_q    <= 1'b0;
         d_wdata_q <= '0;
         line_q    <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_ic_q <= last_ic_d;
         ic_base_q <= ic_base_d;
         d_waddr_q <= d_waddr_d;
         d_we_q    <= d_we_d;
         d_wdata_q <= d_wdata_d;
         line_q    <= line_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_ic_d = last_ic_q;
      ic_base_d = ic_base_q;
      d_waddr_d = d_waddr_q;
      d_we_d    = d_we_q;
      d_wdata_d = d_wdata_q;
      line_d    = line_q;
      rdata_d   = rdata_q;

      case (state_q)
         StIdle: begin
            // On contention the requester not served last wins.
            if (ic_req && (!d_req || !last_ic_q)) begin
               state_d   = StIcReq;
               ic_base_d = ic_addr[ADDR_W-1 -: BASE_W];
               cnt_d     = '0;
            end else if (d_req) begin
               state_d   = StDReq;
               d_waddr_d = d_addr[ADDR_W-1:2];
               d_we_d    = d_we;
               d_wdata_d = d_wdata;
            end
         end
         StIcReq: begin
            if (mem_gnt) begin
               state_d = StIcWait;
            end
         end
         StIcWait: begin
            if (mem_rvalid) begin
               line_d[cnt_q] = mem_rdata;
               if (cnt_q == CNT_LAST) begin
                  state_d = StIcDone;
               end else begin
                  cnt_d   = cnt_q + OFF_W'(1);
                  state_d = StIcReq;
               end
            end
         end
         StIcDone: begin
            cnt_d     = '0;
            last_ic_d = 1'b1;
            state_d   = StIdle;
         end
         StDReq: begin
            if (mem_gnt) begin
               state_d = d_we_q ? StDDone : StDWait;
            end
         end
         StDWait: begin
            if (mem_rvalid) begin
               rdata_d = mem_rdata;
               state_d = StDDone;
            end
         end
         StDDone: begin
            last_ic_d = 1'b0;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decode from state and registers only; no mem_* input reaches an output.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ic_done   = 1'b0;
      ic_busy   = 1'b0;
      d_done    = 1'b0;

      case (state_q)
         StIcReq: begin
            mem_req  = 1'b1;
            mem_addr = {ic_base_q, cnt_q, 2'b00};
            ic_busy  = 1'b1;
         end
         StIcWait: begin
            ic_busy = 1'b1;
         end
         StIcDone: begin
            ic_busy = 1'b1;
            ic_done = 1'b1;
         end
         StDReq: begin
            mem_req   = 1'b1;
            mem_we    = d_we_q;
            mem_addr  = {d_waddr_q, 2'b00};
            mem_wdata = d_wdata_q;
         end
         StDDone: begin
            d_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign ic_line = line_q;
   assign d_rdata = rdata_q;

   assert property (@(posedge CLK) disable iff (!RST_N) ic_done |=> !ic_done);
   assert property (@(posedge CLK) disable iff (!RST_N) !(ic_done && d_done));

endmodule
